lsu_mem: RTL and testbench

Load/store unit directly downstream of the execute stage in the single-cycle core. It takes the computed memory address, the store data (rs2) and funct3, and runs one access on a request/grant/response data bus. It aligns byte enables and write data, extracts and sign/zero-extends load data, and holds `stall` high so the PC and register file freeze until the access retires.

---
 rtl/lsu_mem.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_mem.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit that runs one access on a request/grant/response bus.
// Latency: store >= 3 cycles (IDLE, REQ, DONE); load >= 4 cycles (IDLE, REQ, WAIT_R, DONE).
// Backpressure: stall holds the core frozen until DONE; a timeout aborts the access with err.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   req_load, req_store        access request from execute (load wins if both are set)
//   funct3, addr_mem, data_rs2 access size/sign, byte address, store data
//   stall                      combinational core freeze
//   load_valid, load_data      regfile write enable and extended load result
//   err                        one-cycle pulse on timeout (or misaligned access when trapping)
//   bus_req/we/addr/be/wdata   registered request fields
//   bus_gnt, bus_rvalid, bus_rdata  bus grant and read response
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to abort misaligned half/word
// accesses with err instead of silently aligning them.
module lsu_mem #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_mem,
  input  logic [31:0] data_rs2,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Counter value in the last cycle allowed in REQ+WAIT_R.
  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  // Access size codes.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_is_load;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_err;

  logic        w_start;
  logic [1:0]  w_size;
  logic        w_sign;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic        w_timeout;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign w_start   = req_load | req_store;
  assign w_timeout = (r_cnt == TO_LAST);

  // Request decode. Unlisted funct3 codes fall back to a zero-extended word.
  always_comb begin
    w_size = SZ_W;
    w_sign = 1'b0;
    case (funct3)
      3'b000: begin w_size = SZ_B; w_sign = 1'b1; end
      3'b001: begin w_size = SZ_H; w_sign = 1'b1; end
      3'b100: w_size = SZ_B;
      3'b101: w_size = SZ_H;
      default: ;
    endcase
  end

  // Lane steering. Misaligned halves/words are forced onto their natural
  // boundary; the offset latched here is reused to extract load data.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = data_rs2;
    case (w_size)
      SZ_B: begin
        w_off   = addr_mem[1:0];
        w_be    = 4'b0001 << addr_mem[1:0];
        w_wdata = {4{data_rs2[7:0]}};
      end
      SZ_H: begin
        w_off   = {addr_mem[1], 1'b0};
        w_be    = addr_mem[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_rs2[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = ((w_size == SZ_H) & addr_mem[0]) |
                  ((w_size == SZ_W) & (addr_mem[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Load extraction from the latched offset/size/sign.
  assign w_shift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (r_size)
      SZ_B: w_ext = r_sign ? {{24{w_shift[7]}}, w_shift[7:0]}   : {24'h0, w_shift[7:0]};
      SZ_H: w_ext = r_sign ? {{16{w_shift[15]}}, w_shift[15:0]} : {16'h0, w_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_off        <= 2'b00;
      r_size       <= SZ_W;
      r_sign       <= 1'b0;
      r_is_load    <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'h0;
      r_bus_be     <= 4'h0;
      r_bus_wdata  <= 32'h0;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Both pulses are only ever high for the single DONE cycle.
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_load <= req_load;
            r_size    <= w_size;
            r_sign    <= w_sign;
            r_off     <= w_off;
            if (w_trap) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= 8'd0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= ~req_load;
              r_bus_addr  <= {addr_mem[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          // A grant in the final allowed cycle still wins over the timeout.
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_is_load ? S_WAIT_R : S_DONE;
          end else if (w_timeout) begin
            r_bus_req   <= 1'b0;
            r_state     <= S_DONE;
            r_err       <= 1'b1;
            r_load_data <= 32'h0;
          end
        end
        S_WAIT_R: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_rvalid) begin
            r_load_data  <= w_ext;
            r_load_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            r_err       <= 1'b1;
            r_load_data <= 32'h0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational so the core freezes in the very cycle the request appears.
  assign stall = rst_n & (((r_state == S_IDLE) & w_start) |
                          (r_state == S_REQ) | (r_state == S_WAIT_R));

  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;
  assign err        = r_err;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: scoreboard bench for lsu_mem with a behavioural access model.
module tb_lsu_mem;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr_mem = 32'h0;
  logic [31:0] data_rs2 = 32'h0;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_mem #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_load(req_load), .req_store(req_store), .funct3(funct3),
    .addr_mem(addr_mem), .data_rs2(data_rs2),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        lv;
    logic        er;
    logic [31:0] data;
    int          stall_cyc;
  } rsp_exp_t;

  bus_exp_t exp_bus[$];
  rsp_exp_t exp_rsp[$];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ld = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every grant and every retirement against the queues.
  initial begin : monitor
    logic     prev_stall;
    int       scnt;
    bit       retire;
    bus_exp_t b;
    rsp_exp_t r;
    prev_stall = 1'b0;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        scnt = 0;
      end else begin
        if (bus_req && bus_gnt) begin
          if (exp_bus.size() == 0) chk("bus_unexpected_grant", 32'd1, 32'd0);
          else begin
            b = exp_bus.pop_front();
            chk("bus_we", 32'(bus_we), 32'(b.we));
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_be", 32'(bus_be), 32'(b.be));
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
          end
        end
        retire = prev_stall && !stall;
        if (retire) begin
          if (exp_rsp.size() == 0) chk("retire_unexpected", 32'd1, 32'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("load_valid", 32'(load_valid), 32'(r.lv));
            chk("err", 32'(err), 32'(r.er));
            chk("load_data", load_data, r.data);
            chk("stall_cycles", 32'(scnt), 32'(r.stall_cyc));
            chk("bus_req_done", 32'(bus_req), 32'd0);
          end
        end else begin
          chk("stray_load_valid", 32'(load_valid), 32'd0);
          chk("stray_err", 32'(err), 32'd0);
        end
        scnt = stall ? scnt + 1 : 0;
        prev_stall = stall;
      end
    end
  end

  // One access: pushes the expected outcome, then plays the bus side.
  // gd = REQ cycles before grant (<0: never), rd = WAIT_R cycles before rvalid (<0: never).
  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdat,
                           input int gd, input int rd);
    int n, off, gk, rk, k;
    bit sgn, trap, tmo, in_req, in_wait;
    logic [3:0]  be;
    logic [31:0] wd, sh, mask, v;
    bus_exp_t b;
    rsp_exp_t r;

    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      default:    n = 4;
    endcase
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    off = int'(a[1:0]);
    if (n == 2) off = off & 2;
    if (n == 4) off = 0;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    be   = 4'(((1 << n) - 1) << off);
    wd   = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
    sh   = rdat >> (8 * off);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v    = sh & mask;
    if (sgn && n < 4 && sh[8*n-1]) v = v | ~mask;
    tmo  = !trap && (gd < 0 || (ld && rd < 0));

    if (!trap && gd >= 0) begin
      b.we = !ld; b.addr = {a[31:2], 2'b00}; b.be = be; b.wdata = wd;
      exp_bus.push_back(b);
    end
    if (trap) begin
      r.lv = 1'b0; r.er = 1'b1; r.data = exp_ld; r.stall_cyc = 1;
    end else if (tmo) begin
      exp_ld = 32'h0;
      r.lv = 1'b0; r.er = 1'b1; r.data = 32'h0; r.stall_cyc = 1 + TO;
    end else if (!ld) begin
      r.lv = 1'b0; r.er = 1'b0; r.data = exp_ld; r.stall_cyc = 2 + gd;
    end else begin
      exp_ld = v;
      r.lv = 1'b1; r.er = 1'b0; r.data = v; r.stall_cyc = 3 + gd + rd;
    end
    exp_rsp.push_back(r);

    gk = (gd < 0) ? -1 : 1 + gd;
    rk = (!ld || rd < 0 || gk < 0) ? -1 : gk + 1 + rd;

    req_load  = ld;
    req_store = ld ? 1'($urandom_range(0, 1)) : 1'b1;
    funct3    = f3;
    addr_mem  = a;
    data_rs2  = d;
    k = 0;
    forever begin
      // Noise is only driven where the bus must be ignored.
      in_req  = !trap && k >= 1 && ((gk < 0) ? (k <= TO) : (k < gk));
      in_wait = ld && !trap && gk >= 0 && k > gk && k <= TO && (rk < 0 || k < rk);
      bus_gnt    = (!trap && k == gk) ? 1'b1 : in_req ? 1'b0 : 1'($urandom_range(0, 1));
      bus_rvalid = (!trap && k == rk) ? 1'b1 : in_wait ? 1'b0 : 1'($urandom_range(0, 1));
      bus_rdata  = (k == rk) ? rdat : $urandom;
      @(negedge clk);
      if (!stall) break;
      k++;
      if (k > TO + 8) begin
        chk("access_cycle_bound", 32'(k), 32'(TO + 8));
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_load  = 1'b0;
    req_store = 1'b0;
    bus_gnt   = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic idle_noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus_gnt    = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  initial begin : driver
    bus_exp_t b;
    // Reset values, with a pending request that must not raise stall.
    req_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    req_load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_access(1'b0, 3'b000, 32'h0000_1003, 32'hAABB_CC5A, 32'h0, 0, 0);
    do_access(1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 0, 2);
    chk("lb_result", load_data, 32'hFFFF_FFF0);
    do_access(1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 0);
    chk("lhu_result", load_data, 32'h0000_8001);
    do_access(1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);
    chk("lh_result", load_data, 32'hFFFF_8001);
    do_access(1'b1, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, -1, 0);
    chk("timeout_load_data", load_data, 32'h0);
    idle_noise(3);

    // Reset in WAIT_R.
    req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr_mem = 32'h0000_4000;
    b.we = 1'b0; b.addr = 32'h0000_4000; b.be = 4'hF; b.wdata = 32'h0;
    exp_bus.push_back(b);
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_load_valid", 32'(load_valid), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    req_load = 1'b0;
    rst_n = 1'b1;
    exp_ld = 32'h0;
    @(posedge clk); #1;
    do_access(1'b1, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 0, 0);
    chk("lw_after_reset", load_data, 32'hCAFE_F00D);

    // Misaligned word load.
    do_access(1'b1, 3'b010, 32'h0000_3002, 32'h0, 32'h1234_5678, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_misaligned", load_data, 32'hCAFE_F00D);
`else
    chk("lw_misaligned", load_data, 32'h1234_5678);
`endif

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      int gd, rd;
      gd = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 10));
      rd = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, gd, rd);
      if ($urandom_range(0, 2) == 0) idle_noise(int'($urandom_range(1, 3)));
    end

    idle_noise(3);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    chk("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
